cic_decim: RTL and testbench

//   Third-order CIC (sinc^3) decimator for the 1-bit iCESDM modulator bitstream.

---
 rtl/cic_pkg.sv | 15 +
 rtl/cic_comb_stage.sv | 31 +++
 rtl/cic_decim.sv | 140 ++++++++++++++
 tb/tb_cic_decim.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants, types and helpers for the sinc^3 decimator.
// Internal accumulator width grows by log2(DECIM) bits per stage.
package cic_pkg;

    localparam int CIC_ORDER     = 3;
    localparam int CIC_DECIM_DEF = 64;

    // Two's-complement width needed by an ORDER-stage CIC at ratio DECIM
    function automatic int cic_width(input int order, input int decim);
        return order * $clog2(decim) + 2;
    endfunction

    typedef logic signed [cic_width(CIC_ORDER, CIC_DECIM_DEF)-1:0] cic_acc_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One registered comb section: y = x - x_prev.
// Advances only when its pipeline slot is valid.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int WIDTH = cic_width(CIC_ORDER, CIC_DECIM_DEF)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] x_prev_q;
    logic [WIDTH-1:0] y_q;

    // Difference against the previous decimated sample, modulo 2^WIDTH
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_prev_q <= '0;
            y_q      <= '0;
        end else if (i_en) begin
            y_q      <= i_x - x_prev_q;
            x_prev_q <= i_x;
        end
    end

    assign o_y = y_q;

endmodule

// File: rtl/cic_decim.sv
// Third-order CIC decimator for a 1-bit sigma-delta stream.
// Integrators run at the sample rate, combs at fs/DECIM.
module cic_decim
    import cic_pkg::*;
#(
    parameter int ORDER     = 3,
    parameter int DECIM     = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_data,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun
);

    localparam int W  = cic_width(ORDER, DECIM);
    localparam int CW = $clog2(DECIM);

    if (ORDER != CIC_ORDER) begin : g_bad_order
        $error("cic_decim: ORDER must be 3");
    end
    if (DECIM < 4 || (DECIM & (DECIM - 1)) != 0) begin : g_bad_decim
        $error("cic_decim: DECIM must be a power of two >= 4");
    end
    if (OUT_WIDTH > W || OUT_WIDTH < 1) begin : g_bad_ow
        $error("cic_decim: OUT_WIDTH must be in 1..W");
    end

    logic signed [W-1:0] int_q [ORDER];
    logic signed [W-1:0] int_d [ORDER];
    logic signed [W-1:0] step;
    logic [CW-1:0]       cnt_q;
    logic                tick;
    logic [W-1:0]        cap_q;
    logic [ORDER:0]      vld_q;
    logic [W-1:0]        cmb [ORDER+1];

    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 new_word;

    // Integrator next state; each stage adds the previous stage's registered value
    always_comb begin
        step = i_data ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
        int_d[0] = int_q[0] + step;
        for (int k = 1; k < ORDER; k++) begin
            int_d[k] = int_q[k] + int_q[k-1];
        end
    end

    assign tick = i_en && (cnt_q == CW'(DECIM - 1));

    // Integrators and sample counter hold while no sample is offered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < ORDER; k++) begin
                int_q[k] <= '0;
            end
            cnt_q <= '0;
        end else if (i_en) begin
            for (int k = 0; k < ORDER; k++) begin
                int_q[k] <= int_d[k];
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Capture the last integrator on the tick and walk a valid bit down the combs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_q <= '0;
            vld_q <= '0;
        end else begin
            if (tick) begin
                cap_q <= int_d[ORDER-1];
            end
            vld_q <= {vld_q[ORDER-1:0], tick};
        end
    end

    assign cmb[0] = cap_q;

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb_stage #(
            .WIDTH (W)
        ) u_comb (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_en    (vld_q[g]),
            .i_x     (cmb[g]),
            .o_y     (cmb[g+1])
        );
    end

    if (OUT_WIDTH < W) begin : g_lo
        logic unused_lo;
        assign unused_lo = ^cmb[ORDER][W-OUT_WIDTH-1:0];
    end

    assign new_word = vld_q[ORDER];

    // Output holding register: a new word always wins, overwrite of an unread word is flagged
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (new_word) begin
            data_d  = cmb[ORDER][W-1 -: OUT_WIDTH];
            valid_d = 1'b1;
            if (valid_q && !i_ready) begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    // Registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_cic_decim.sv
// Directed bench for cic_decim at default parameters.
// Expected words are hand-derived from the sinc^3 full-scale gain.
module tb_cic_decim;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        din;
    logic        ready;
    logic [15:0] data;
    logic        valid;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    logic [15:0] words [8];
    int          wcyc  [8];
    int          nw;
    int          vmax;

    always #5 clk = ~clk;

    cic_decim dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_en      (en),
        .i_data    (din),
        .o_data    (data),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_overrun (overrun)
    );

    function automatic logic pat(input int mode, input int idx);
        case (mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return (idx % 2) == 0;
            default: return (idx % 4) != 3;
        endcase
    endfunction

    task automatic do_reset();
        en    = 1'b0;
        din   = 1'b0;
        ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_words(input int mode, input int per, input int nwant);
        int sidx;
        int vrun;
        sidx = 0;
        vrun = 0;
        nw   = 0;
        vmax = 0;
        for (int c = 0; c < nwant * 64 * per + 64; c++) begin
            en    = (c % per) == 0;
            din   = pat(mode, sidx);
            ready = 1'b1;
            @(posedge clk);
            #1;
            if (en) sidx++;
            if (valid) begin
                vrun++;
                if (nw < 8) begin
                    words[nw] = data;
                    wcyc[nw]  = c;
                end
                nw++;
            end else begin
                vrun = 0;
            end
            if (vrun > vmax) vmax = vrun;
        end
        en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 3;
        if (data !== 16'h0) begin
            failures++;
            $display("FAIL rst_data got=%h exp=0000", data);
        end
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid got=%b exp=0", valid);
        end
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL rst_ovr got=%b exp=0", overrun);
        end
        en  = 1'b1;
        din = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checks += 2;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_valid got=%b exp=1", valid);
        end
        if (overrun !== 1'b1) begin
            failures++;
            $display("FAIL pre_ovr got=%b exp=1", overrun);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (data !== 16'h0) begin
            failures++;
            $display("FAIL async_data got=%h exp=0000", data);
        end
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL async_valid got=%b exp=0", valid);
        end
        if (overrun !== 1'b0) begin
            failures++;
            $display("FAIL async_ovr got=%b exp=0", overrun);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 68; e++) begin
            @(posedge clk);
            #1;
            if (e == 67) begin
                checks++;
                if (valid !== 1'b0) begin
                    failures++;
                    $display("FAIL lat_early got=%b exp=0", valid);
                end
            end
            if (e == 68) begin
                checks++;
                if (valid !== 1'b1) begin
                    failures++;
                    $display("FAIL lat_first got=%b exp=1", valid);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_const(input int mode, input logic [15:0] exp, input int per);
        int gap;
        do_reset();
        run_words(mode, per, 5);
        gap = 64 * per;
        checks++;
        if (nw !== 5) begin
            failures++;
            $display("FAIL m%0d_count got=%0d exp=5", mode, nw);
        end
        checks++;
        if (vmax !== 1) begin
            failures++;
            $display("FAIL m%0d_pulse got=%0d exp=1", mode, vmax);
        end
        for (int k = 2; k < 5; k++) begin
            checks++;
            if (words[k] !== exp) begin
                failures++;
                $display("FAIL m%0d_word%0d got=%h exp=%h", mode, k + 1, words[k], exp);
            end
        end
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (wcyc[k] - wcyc[k-1] !== gap) begin
                failures++;
                $display("FAIL m%0d_gap%0d got=%0d exp=%0d", mode, k, wcyc[k] - wcyc[k-1], gap);
            end
        end
    endtask

    task automatic test_density();
        int sum;
        do_reset();
        run_words(3, 1, 5);
        sum = 0;
        for (int k = 2; k < 5; k++) sum += int'($signed(words[k]));
        checks++;
        if (nw !== 5 || sum < 3 * 8190 || sum > 3 * 8194) begin
            failures++;
            $display("FAIL dens75 got_sum=%0d words=%0d exp_sum=%0d", sum, nw, 3 * 8192);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        en = 1'b1;
        for (int e = 1; e <= 388; e++) begin
            din   = (e <= 192);
            ready = (e <= 196);
            @(posedge clk);
            #1;
            if (e == 196) begin
                checks++;
                if (valid !== 1'b1 || data !== 16'h4000 || overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL ovr_w3 got=%b/%h/%b exp=1/4000/0", valid, data, overrun);
                end
            end
            if (e == 260) begin
                checks++;
                if (overrun !== 1'b1 || valid !== 1'b1) begin
                    failures++;
                    $display("FAIL ovr_set got=%b/%b exp=1/1", overrun, valid);
                end
            end
            if (e == 388) begin
                checks++;
                if (valid !== 1'b1 || data !== 16'hC000 || overrun !== 1'b1) begin
                    failures++;
                    $display("FAIL ovr_last got=%b/%h/%b exp=1/c000/1", valid, data, overrun);
                end
            end
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        en  = 1'b1;
        din = 1'b1;
        for (int e = 1; e <= 133; e++) begin
            ready = (e >= 132);
            @(posedge clk);
            #1;
            if (e == 131) begin
                checks++;
                if (valid !== 1'b1 || overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_hold got=%b/%b exp=1/0", valid, overrun);
                end
            end
            if (e == 132) begin
                checks++;
                if (valid !== 1'b1 || overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_same got=%b/%b exp=1/0", valid, overrun);
                end
            end
            if (e == 133) begin
                checks++;
                if (valid !== 1'b0 || overrun !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_drop got=%b/%b exp=0/0", valid, overrun);
                end
            end
        end
        en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        ready = 1'b0;
        test_reset();
        test_const(0, 16'h4000, 1);
        test_const(1, 16'hC000, 1);
        test_const(2, 16'h0000, 1);
        test_density();
        test_overrun();
        test_back_to_back();
        test_const(0, 16'h4000, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
